if_fetch_stage: RTL and testbench

Instruction-fetch stage and IF/ID pipeline register of the pipelined RV32 core. It generates the PC, issues single-outstanding requests to instruction memory, and buffers one returned word. It presents the instruction to decode under the stall and redirect control produced by the hazard detection unit and branch resolution. It is the direct upstream producer of the `id_*` operands whose register fields (`id_rs1_addr`, `id_rs2_addr`) the hazard unit compares.

---
 rtl/if_fetch_stage.sv | 192 +++++++++++++++++++
 tb/tb_if_fetch_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: RV32 instruction-fetch stage with the IF/ID pipeline register.
// Generates the PC, keeps at most one instruction-memory request in flight,
// buffers one returned word while decode is stalled, and squashes fetches on
// a redirect.
// Optional feature: define IF_PERF_CNT_EN to build the two performance counters;
// without it, perf_fetched and perf_stall_cycles are tied to zero.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_if,
   input  logic        stall_id,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_plus4,
   output logic [31:0] id_instr,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stall_cycles
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   // REQ: may issue; WAIT: one request outstanding; KILL: outstanding
   // response belongs to a squashed path and must be dropped.
   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_KILL = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic        fb_valid_q, fb_valid_d;
   logic [31:0] fb_pc_q, fb_pc_d;
   logic [31:0] fb_instr_q, fb_instr_d;
   logic        id_valid_q, id_valid_d;
   logic [31:0] id_pc_q, id_pc_d;
   logic [31:0] id_instr_q, id_instr_d;

   logic        fire;
   logic        resp_ok;
   logic [31:0] target_aligned;

   // Request is combinational from registered state; suppressed during reset.
   assign imem_req       = !rst && (state_q == S_REQ) && !fb_valid_q && !stall_if;
   assign imem_addr      = pc_q;
   assign fire           = imem_req && imem_gnt;
   assign resp_ok        = (state_q == S_WAIT) && imem_rvalid;
   assign target_aligned = branch_target & ~32'h0000_0003;

   // Next-state for the fetch FSM, PC, fetch buffer and IF/ID register.
   always_comb begin
      // NOTE: every target gets a default first so no path can infer a latch.
      state_d    = state_q;
      pc_d       = pc_q;
      req_pc_d   = req_pc_q;
      fb_valid_d = fb_valid_q;
      fb_pc_d    = fb_pc_q;
      fb_instr_d = fb_instr_q;
      id_valid_d = id_valid_q;
      id_pc_d    = id_pc_q;
      id_instr_d = id_instr_q;

      unique case (state_q)
         S_REQ: begin
            if (fire) begin
               req_pc_d = pc_q;
               pc_d     = pc_q + 32'd4;
               state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               state_d = S_REQ;
               // A stalled decode parks the word in the buffer; the buffer is
               // always empty here because issue requires fb_valid_q == 0.
               if (stall_id) begin
                  fb_valid_d = 1'b1;
                  fb_pc_d    = req_pc_q;
                  fb_instr_d = imem_rdata;
               end
            end
         end
         S_KILL: begin
            if (imem_rvalid) state_d = S_REQ;
         end
         default: state_d = S_REQ;
      endcase

      // IF/ID register, highest priority first.
      if (branch_taken) begin
         id_valid_d = 1'b0;
         id_instr_d = NOP;
      end else if (stall_id) begin
         id_valid_d = id_valid_q;
      end else if (fb_valid_q) begin
         id_valid_d = 1'b1;
         id_pc_d    = fb_pc_q;
         id_instr_d = fb_instr_q;
         fb_valid_d = 1'b0;
      end else if (resp_ok) begin
         id_valid_d = 1'b1;
         id_pc_d    = req_pc_q;
         id_instr_d = imem_rdata;
      end else begin
         id_valid_d = 1'b0;
         id_instr_d = NOP;
      end

      // Redirect overrides everything: squash the buffer and any fetch that
      // is in flight or granted this cycle. A response arriving together
      // with the redirect is the one being squashed, so no KILL is needed.
      if (branch_taken) begin
         pc_d       = target_aligned;
         fb_valid_d = 1'b0;
         if (state_q == S_WAIT)      state_d = imem_rvalid ? S_REQ : S_KILL;
         else if (state_q == S_REQ)  state_d = fire ? S_KILL : S_REQ;
      end
   end

   // State registers for the FSM, PC, fetch buffer and IF/ID register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_REQ;
         pc_q       <= RESET_PC;
         req_pc_q   <= 32'd0;
         fb_valid_q <= 1'b0;
         fb_pc_q    <= 32'd0;
         fb_instr_q <= NOP;
         id_valid_q <= 1'b0;
         id_pc_q    <= 32'd0;
         id_instr_q <= NOP;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values.
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_pc_q   <= req_pc_d;
         fb_valid_q <= fb_valid_d;
         fb_pc_q    <= fb_pc_d;
         fb_instr_q <= fb_instr_d;
         id_valid_q <= id_valid_d;
         id_pc_q    <= id_pc_d;
         id_instr_q <= id_instr_d;
      end
   end

   assign id_valid    = id_valid_q;
   assign id_pc       = id_pc_q;
   assign id_pc_plus4 = id_pc_q + 32'd4;
   assign id_instr    = id_instr_q;

`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetched_q, perf_fetched_d;
   logic [31:0] perf_stall_q, perf_stall_d;

   // Counter next-state: accepted responses and stalled live-decode cycles.
   always_comb begin
      perf_fetched_d = perf_fetched_q;
      perf_stall_d   = perf_stall_q;
      if (resp_ok && !branch_taken)             perf_fetched_d = perf_fetched_q + 32'd1;
      if (stall_id && id_valid_q && !branch_taken) perf_stall_d = perf_stall_q + 32'd1;
   end

   // Performance counter registers; both wrap naturally at 2^32.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetched_q <= 32'd0;
         perf_stall_q   <= 32'd0;
      end else begin
         perf_fetched_q <= perf_fetched_d;
         perf_stall_q   <= perf_stall_d;
      end
   end

   assign perf_fetched      = perf_fetched_q;
   assign perf_stall_cycles = perf_stall_q;
`else
   assign perf_fetched      = 32'd0;
   assign perf_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed bench for if_fetch_stage (RESET_PC = 0x100).
// Walks boot, load-use stall, buffer path, in-flight redirect, simultaneous
// redirect/response/stall, PC wrap and mid-operation reset.
module tb_if_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IF_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_if, stall_id, branch_taken;
   logic [31:0] branch_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt, imem_rvalid;
   logic [31:0] imem_rdata;
   logic        id_valid;
   logic [31:0] id_pc, id_pc_plus4, id_instr;
   logic [31:0] perf_fetched, perf_stall_cycles;

   int n_assert = 0;
   int n_fail   = 0;

   if_fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
      .clk              (clk),
      .rst              (rst),
      .stall_if         (stall_if),
      .stall_id         (stall_id),
      .branch_taken     (branch_taken),
      .branch_target    (branch_target),
      .imem_req         (imem_req),
      .imem_addr        (imem_addr),
      .imem_gnt         (imem_gnt),
      .imem_rvalid      (imem_rvalid),
      .imem_rdata       (imem_rdata),
      .id_valid         (id_valid),
      .id_pc            (id_pc),
      .id_pc_plus4      (id_pc_plus4),
      .id_instr         (id_instr),
      .perf_fetched     (perf_fetched),
      .perf_stall_cycles(perf_stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs are then changed well away from it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] pexp(input logic [31:0] v);
      return PERF ? v : 32'd0;
   endfunction

   initial begin
      rst = 1'b1; stall_if = 1'b0; stall_id = 1'b0; branch_taken = 1'b0;
      branch_target = 32'd0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
      tick(); tick();
      #1;
      // Reset state
      check("rst_req",     {31'd0, imem_req}, 32'd0);
      check("rst_addr",    imem_addr, 32'h100);
      check("rst_valid",   {31'd0, id_valid}, 32'd0);
      check("rst_pc",      id_pc, 32'd0);
      check("rst_pc4",     id_pc_plus4, 32'd4);
      check("rst_instr",   id_instr, NOP);
      check("rst_pfetch",  perf_fetched, 32'd0);
      check("rst_pstall",  perf_stall_cycles, 32'd0);

      // Boot: first request at 0x100, granted
      rst = 1'b0; imem_gnt = 1'b1;
      #1;
      check("boot_req",  {31'd0, imem_req}, 32'd1);
      check("boot_addr", imem_addr, 32'h100);
      tick();
      // WAIT: response arrives one cycle after grant
      imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
      #1;
      check("wait_noreq", {31'd0, imem_req}, 32'd0);
      tick();
      imem_rvalid = 1'b0;
      #1;
      check("boot_valid", {31'd0, id_valid}, 32'd1);
      check("boot_pc",    id_pc, 32'h100);
      check("boot_pc4",   id_pc_plus4, 32'h104);
      check("boot_instr", id_instr, 32'h0050_0093);
      check("addr2",      imem_addr, 32'h104);
      check("req2",       {31'd0, imem_req}, 32'd1);
      tick();
      // Second fetch in flight: IF/ID shows a bubble
      imem_rvalid = 1'b1; imem_rdata = 32'h0010_8113;
      #1;
      check("bubble_valid", {31'd0, id_valid}, 32'd0);
      check("bubble_instr", id_instr, NOP);
      tick();

      // Load-use stall for two cycles with 0x104 in IF/ID
      imem_rvalid = 1'b0; stall_if = 1'b1; stall_id = 1'b1;
      #1;
      check("lu_pc",    id_pc, 32'h104);
      check("lu_instr", id_instr, 32'h0010_8113);
      check("lu_req",   {31'd0, imem_req}, 32'd0);
      tick();
      #1;
      check("lu_pc2",    id_pc, 32'h104);
      check("lu_valid2", {31'd0, id_valid}, 32'd1);
      check("lu_req2",   {31'd0, imem_req}, 32'd0);
      check("lu_pstall1", perf_stall_cycles, pexp(32'd1));
      tick();
      // Buffer path: decode still stalled, fetch allowed
      stall_if = 1'b0;
      #1;
      check("lu_pstall2", perf_stall_cycles, pexp(32'd2));
      check("fb_req",  {31'd0, imem_req}, 32'd1);
      check("fb_addr", imem_addr, 32'h108);
      tick();
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0000_0213;
      tick();
      imem_rvalid = 1'b0; stall_id = 1'b0;
      #1;
      check("fb_noreq", {31'd0, imem_req}, 32'd0);
      check("fb_hold",  id_pc, 32'h104);
      tick();
      #1;
      check("fb_pc",    id_pc, 32'h108);
      check("fb_instr", id_instr, 32'h0000_0213);
      check("fb_valid", {31'd0, id_valid}, 32'd1);
      check("fb_req2",  {31'd0, imem_req}, 32'd1);
      check("fb_addr2", imem_addr, 32'h10C);
      check("pfetch3",  perf_fetched, pexp(32'd3));
      check("pstall4",  perf_stall_cycles, pexp(32'd4));

      // Redirect while the 0x10C fetch is outstanding
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0; branch_taken = 1'b1; branch_target = 32'h203;
      tick();
      branch_taken = 1'b0;
      #1;
      check("kill_noreq", {31'd0, imem_req}, 32'd0);
      check("kill_valid", {31'd0, id_valid}, 32'd0);
      imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      tick();
      imem_rvalid = 1'b0;
      #1;
      check("redir_valid", {31'd0, id_valid}, 32'd0);
      check("redir_instr", id_instr, NOP);
      check("redir_req",   {31'd0, imem_req}, 32'd1);
      check("redir_addr",  imem_addr, 32'h200);
      check("redir_pfetch", perf_fetched, pexp(32'd3));

      // Redirect together with response and decode stall
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
      stall_id = 1'b1; branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
      tick();
      imem_rvalid = 1'b0; stall_id = 1'b0; branch_taken = 1'b0;
      #1;
      check("sim_valid", {31'd0, id_valid}, 32'd0);
      check("sim_req",   {31'd0, imem_req}, 32'd1);
      check("sim_addr",  imem_addr, 32'hFFFF_FFFC);
      check("sim_pfetch", perf_fetched, pexp(32'd3));
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      #1;
      check("sim_nofb", {31'd0, id_valid}, 32'd0);
      imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222;
      tick();
      imem_rvalid = 1'b0;
      #1;
      // Wrap at the top of the address space
      check("wrap_pc",    id_pc, 32'hFFFF_FFFC);
      check("wrap_pc4",   id_pc_plus4, 32'd0);
      check("wrap_instr", id_instr, 32'h2222_2222);
      check("wrap_addr",  imem_addr, 32'd0);
      check("wrap_req",   {31'd0, imem_req}, 32'd1);
      check("wrap_pfetch", perf_fetched, pexp(32'd4));
      check("wrap_pstall", perf_stall_cycles, pexp(32'd4));

      // Reset mid-operation with a fetch outstanding; late response ignored
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      rst = 1'b1;
      #1;
      check("mrst_req",    {31'd0, imem_req}, 32'd0);
      check("mrst_valid",  {31'd0, id_valid}, 32'd0);
      check("mrst_pc4",    id_pc_plus4, 32'd4);
      check("mrst_pfetch", perf_fetched, 32'd0);
      tick();
      rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h3333_3333;
      tick();
      imem_rvalid = 1'b0;
      #1;
      check("stray_valid", {31'd0, id_valid}, 32'd0);
      check("stray_instr", id_instr, NOP);
      check("stray_addr",  imem_addr, 32'h100);
      check("stray_req",   {31'd0, imem_req}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
